mux8x1_reg: RTL and testbench
=============================

Name: mux8x1_reg

Overview:
- Eight-input, one-output word selector with a registered output stage.
- Used wherever the datapath (ALU result select, writeback source, immediate select) picks one of eight equal-width operands by a 3-bit code.
- Select mapping is fixed: code n returns input a<n>.
- Optional pass-through mode gives a purely combinational path for single-cycle datapaths.

Parameters:
- WIDTH, 32, bit width of every data input and the output.
- REG_OUT, 1, 1 = output registered (1-cycle latency); 0 = combinational output, registers bypassed.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- a0..a7  input  WIDTH each  data operands, a0 selected by code 0 … a7 by code 7.
- sel  input  3  select code.
- in_valid  input  1  qualifies a0..a7 and sel this cycle.
- y  output  WIDTH  selected word.
- out_valid  output  1  y carries a valid selection.
- sel_q  output  3  select code that produced the current y.

Behaviour:
- Combinational core: y_next = a[sel] for all 8 codes. The case is full, so no latch or X path exists; an X/Z on sel must not propagate beyond the mux.
- REG_OUT=1:
  - On posedge clk with reset=1: y=0, out_valid=0, sel_q=0. Reset has priority over in_valid.
  - On posedge clk with reset=0 and in_valid=1: y<=a[sel], sel_q<=sel, out_valid<=1.
  - On posedge clk with reset=0 and in_valid=0: y and sel_q hold their previous values; out_valid<=0.
  - Latency is exactly 1 cycle from sampled inputs to y.
  - Changes on a0..a7 or sel between edges have no effect until the next edge.
- REG_OUT=0:
  - y=a[sel], sel_q=sel, out_valid=in_valid, all combinational. clk and reset are unused.
  - Output updates within the same delta as any input change, including a change on the selected input alone, such as a7 changing while sel=7.
- Width rule: no truncation or extension; y is bit-exact to the selected input.
- Reset asserted mid-stream: the next edge clears the outputs regardless of in_valid. The first valid sample after reset deasserts appears one cycle later.
- Back-to-back valid cycles: one result per cycle with no bubbles.

Decomposition:
- Shared package: constant SEL_W = 3; localparams SEL_A0..SEL_A7 = 0..7 for callers encoding the select.
- One natural sub-module: mux2x1 (WIDTH-parameterised 2:1 select).
  - Instantiated seven times as a three-level tree.
  - sel[0] drives the leaf level, sel[1] the middle level, sel[2] the root.
- The output register stage and REG_OUT generate block live in mux8x1_reg.

Test Plan:
- Inputs a0..a7 = 12,31,45,121,1234,21312,1,6. Step sel 0..7, one valid cycle each, REG_OUT=1 → y one cycle later = 12,31,45,121,1234,21312,1,6 with out_valid=1 and sel_q equal to that code.
- Hold sel=7 and change a7 from 6 to 3123 → y=6 then 3123 on the following edge. With REG_OUT=0, y=3123 immediately.
- Assert reset while in_valid=1 and sel=5 → y=0, out_valid=0, sel_q=0 after the edge. Release reset → y=21312 one cycle later.
- in_valid=0 after a valid sel=4 → y holds 1234, out_valid falls to 0. Changing a4 to 99 while invalid does not alter y.
- Width check with WIDTH=32: a3=32'hFFFF_FFFF, a2=32'h8000_0001 → sel=3 gives FFFF_FFFF, sel=2 gives 8000_0001, exact.
- Random sweep of 1000 cycles with random inputs, sel and in_valid; a scoreboard compares y against a one-cycle-delayed reference of a[sel], with no mismatches permitted.

Source files
------------

// File: rtl/mux8x1_reg_pkg.sv
// Shared select-code definitions for the 8:1 word selector and its callers.
package mux8x1_reg_pkg;

  localparam int unsigned SEL_W = 3;

  localparam logic [SEL_W-1:0] SEL_A0 = 3'd0;
  localparam logic [SEL_W-1:0] SEL_A1 = 3'd1;
  localparam logic [SEL_W-1:0] SEL_A2 = 3'd2;
  localparam logic [SEL_W-1:0] SEL_A3 = 3'd3;
  localparam logic [SEL_W-1:0] SEL_A4 = 3'd4;
  localparam logic [SEL_W-1:0] SEL_A5 = 3'd5;
  localparam logic [SEL_W-1:0] SEL_A6 = 3'd6;
  localparam logic [SEL_W-1:0] SEL_A7 = 3'd7;

endpackage

// File: rtl/mux8x1_reg_mux2x1.sv
// WIDTH-parameterised 2:1 word select, the leaf cell of the 8:1 tree.
module mux2x1 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  output logic [WIDTH-1:0] y
);

  // An unknown select falls to the 'a' branch instead of smearing X into y.
  always_comb begin
    if (sel) y = b;
    else     y = a;
  end

endmodule

// File: rtl/mux8x1_reg.sv
// Eight-input word selector built as a 2:1 tree, with an optional output register stage.
module mux8x1_reg
  import mux8x1_reg_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter bit          REG_OUT = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] a2,
  input  logic [WIDTH-1:0] a3,
  input  logic [WIDTH-1:0] a4,
  input  logic [WIDTH-1:0] a5,
  input  logic [WIDTH-1:0] a6,
  input  logic [WIDTH-1:0] a7,
  input  logic [SEL_W-1:0] sel,
  input  logic             in_valid,
  output logic [WIDTH-1:0] y,
  output logic             out_valid,
  output logic [SEL_W-1:0] sel_q
);

  logic [WIDTH-1:0] leaf0, leaf1, leaf2, leaf3;
  logic [WIDTH-1:0] mid0, mid1;
  logic [WIDTH-1:0] y_next;

  mux2x1 #(.WIDTH(WIDTH)) u_leaf0 (.a(a0), .b(a1), .sel(sel[0]), .y(leaf0));
  mux2x1 #(.WIDTH(WIDTH)) u_leaf1 (.a(a2), .b(a3), .sel(sel[0]), .y(leaf1));
  mux2x1 #(.WIDTH(WIDTH)) u_leaf2 (.a(a4), .b(a5), .sel(sel[0]), .y(leaf2));
  mux2x1 #(.WIDTH(WIDTH)) u_leaf3 (.a(a6), .b(a7), .sel(sel[0]), .y(leaf3));

  mux2x1 #(.WIDTH(WIDTH)) u_mid0 (.a(leaf0), .b(leaf1), .sel(sel[1]), .y(mid0));
  mux2x1 #(.WIDTH(WIDTH)) u_mid1 (.a(leaf2), .b(leaf3), .sel(sel[1]), .y(mid1));

  mux2x1 #(.WIDTH(WIDTH)) u_root (.a(mid0), .b(mid1), .sel(sel[2]), .y(y_next));

  if (REG_OUT) begin : g_reg
    logic [WIDTH-1:0] y_r;
    logic             valid_r;
    logic [SEL_W-1:0] sel_r;

    // Data and code hold across invalid cycles; only the valid flag drops.
    always_ff @(posedge clk) begin
      if (reset) begin
        y_r     <= '0;
        valid_r <= 1'b0;
        sel_r   <= '0;
      end else begin
        valid_r <= in_valid;
        if (in_valid) begin
          y_r   <= y_next;
          sel_r <= sel;
        end
      end
    end

    assign y         = y_r;
    assign out_valid = valid_r;
    assign sel_q     = sel_r;
  end else begin : g_comb
    logic unused_clk_reset;
    assign unused_clk_reset = clk ^ reset;

    assign y         = y_next;
    assign out_valid = in_valid;
    assign sel_q     = sel;
  end

endmodule

// File: tb/tb_mux8x1_reg.sv
// Scoreboard bench: registered instance checked per cycle, combinational instance checked on every drive.
module tb_mux8x1_reg;

  localparam int unsigned W = 32;

  typedef struct {
    logic         v;
    logic [W-1:0] y;
    logic [2:0]   s;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] a0, a1, a2, a3, a4, a5, a6, a7;
  logic [2:0]   sel = '0;
  logic         in_valid = 1'b0;
  logic [W-1:0] y_r, y_c;
  logic         ov_r, ov_c;
  logic [2:0]   sq_r, sq_c;

  logic [W-1:0] a [8];
  logic [W-1:0] m_y;
  logic [2:0]   m_s;
  exp_t         q [$];
  int           checks = 0;
  int           failures = 0;

  always #5 clk = ~clk;

  mux8x1_reg #(.WIDTH(W), .REG_OUT(1'b1)) dut_reg (
    .clk(clk), .reset(reset),
    .a0(a0), .a1(a1), .a2(a2), .a3(a3), .a4(a4), .a5(a5), .a6(a6), .a7(a7),
    .sel(sel), .in_valid(in_valid),
    .y(y_r), .out_valid(ov_r), .sel_q(sq_r)
  );

  mux8x1_reg #(.WIDTH(W), .REG_OUT(1'b0)) dut_comb (
    .clk(clk), .reset(reset),
    .a0(a0), .a1(a1), .a2(a2), .a3(a3), .a4(a4), .a5(a5), .a6(a6), .a7(a7),
    .sel(sel), .in_valid(in_valid),
    .y(y_c), .out_valid(ov_c), .sel_q(sq_c)
  );

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // One cycle of stimulus; the expected registered response is queued for the next edge.
  task automatic drive(input logic r, input logic v, input logic [2:0] s);
    exp_t e;
    @(negedge clk);
    reset = r; in_valid = v; sel = s;
    a0 = a[0]; a1 = a[1]; a2 = a[2]; a3 = a[3];
    a4 = a[4]; a5 = a[5]; a6 = a[6]; a7 = a[7];
    if (r) begin
      m_y = '0; m_s = '0; e.v = 1'b0;
    end else if (v) begin
      m_y = a[s]; m_s = s; e.v = 1'b1;
    end else begin
      e.v = 1'b0;
    end
    e.y = m_y; e.s = m_s;
    q.push_back(e);
    #1;
    check("comb_y", y_c, a[s]);
    check("comb_out_valid", {{(W-1){1'b0}}, ov_c}, {{(W-1){1'b0}}, v});
    check("comb_sel_q", {{(W-3){1'b0}}, sq_c}, {{(W-3){1'b0}}, s});
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("reg_out_valid", {{(W-1){1'b0}}, ov_r}, {{(W-1){1'b0}}, e.v});
        check("reg_y", y_r, e.y);
        check("reg_sel_q", {{(W-3){1'b0}}, sq_r}, {{(W-3){1'b0}}, e.s});
      end
    end
  end

  initial begin : stimulus
    int unsigned init_vals [8] = '{12, 31, 45, 121, 1234, 21312, 1, 6};
    for (int i = 0; i < 8; i++) a[i] = init_vals[i];
    m_y = '0; m_s = '0;
    a0 = a[0]; a1 = a[1]; a2 = a[2]; a3 = a[3];
    a4 = a[4]; a5 = a[5]; a6 = a[6]; a7 = a[7];

    drive(1'b1, 1'b0, 3'd0);
    drive(1'b1, 1'b1, 3'd6);

    for (int i = 0; i < 8; i++) drive(1'b0, 1'b1, 3'(i));

    a[7] = 32'd3123;
    drive(1'b0, 1'b1, 3'd7);

    drive(1'b1, 1'b1, 3'd5);
    drive(1'b0, 1'b1, 3'd5);

    drive(1'b0, 1'b1, 3'd4);
    drive(1'b0, 1'b0, 3'd4);
    a[4] = 32'd99;
    drive(1'b0, 1'b0, 3'd4);
    drive(1'b0, 1'b0, 3'd1);

    a[3] = 32'hFFFF_FFFF;
    a[2] = 32'h8000_0001;
    drive(1'b0, 1'b1, 3'd3);
    drive(1'b0, 1'b1, 3'd2);

    for (int n = 0; n < 1000; n++) begin
      for (int i = 0; i < 8; i++) a[i] = $urandom;
      drive($urandom_range(31) == 0, $urandom_range(3) != 0, 3'($urandom_range(7)));
    end
    drive(1'b0, 1'b0, 3'd0);

    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
